// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//
// Byte-addressable data memory for the core's load/store path. It handles
// byte, halfword and word accesses. Loads are sign- or zero-extended, and
// stores write only the byte lanes they cover. Each access uses a
// request/ready/valid handshake, and the response latency is set by a
// parameter. Storage is little-endian, and addresses wrap modulo DEPTH_BYTES.
//
// Parameters
//   DEPTH_BYTES  memory size in bytes (power of two, >= 4)
//   LATENCY      cycles from acceptance to response (1..7)
//
// Optional feature (compile-time macro)
//   DMEM_MISALIGN_TRAP_EN  defined   : a misaligned access returns fault_o=1
//                                      and rdata_o=0, and a misaligned store
//                                      leaves memory unchanged
//                          undefined : a misaligned address is aligned down,
//                                      and fault_o is always 0
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset; also clears the memory
//   req_i       access request, accepted when ready_o is high
//   we_i        1 = store, 0 = load
//   size_i      00 byte, 01 halfword, 10/11 word
//   unsigned_i  load only: 1 zero-extends, 0 sign-extends
//   addr_i      byte address, taken modulo DEPTH_BYTES
//   wdata_i     store data; the low 8/16/32 bits are used
//   ready_o     a request can be accepted this cycle
//   rvalid_o    one-cycle completion pulse for loads and stores
//   rdata_o     registered load result; 0 for stores and faults
//   fault_o     registered misalignment flag; valid only with rvalid_o
// ---------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  // The counter is loaded with LATENCY-2 so that the FSM spends
  // LATENCY-1 cycles in WAIT.
  localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept;

  // Request fields latched at acceptance, used when the response is produced
  // after a WAIT period.
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic          mis_q;

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [31:0]   rdata_q;
  logic          fault_q;

  // Only addr_i[AW-1:0] selects a byte; the upper bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:AW];

  // -------------------------------------------------------------------------
  // Request decode: aligned, wrapped address, misalignment flag and the
  // write byte enables.
  // -------------------------------------------------------------------------
  logic [AW-1:0] req_addr;
  logic          req_mis;
  logic [3:0]    req_be;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // that no path can leave it unassigned and infer a latch.
  always_comb begin
    req_addr = addr_i[AW-1:0];
    req_be   = 4'b1111;
    case (size_i)
      2'b00: req_be = 4'b0001;
      2'b01: begin
        req_be      = 4'b0011;
        req_addr[0] = 1'b0;
      end
      default: req_addr[1:0] = 2'b00;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    req_mis = ((size_i == 2'b01) && addr_i[0]) ||
              (size_i[1] && (addr_i[1:0] != 2'b00));
`else
    req_mis = 1'b0;
`endif
  end

  assign accept = req_i && ready_o;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking (<=)
  // assignments, so every flop samples values from before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready_o  = (state_q != ST_WAIT);
    rvalid_o = (state_q == ST_RESP);
  end

  // -------------------------------------------------------------------------
  // Request latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      size_q <= 2'b00;
      uns_q  <= 1'b0;
      addr_q <= '0;
      mis_q  <= 1'b0;
    end else if (accept) begin
      we_q   <= we_i;
      size_q <= size_i;
      uns_q  <= unsigned_i;
      addr_q <= req_addr;
      mis_q  <= req_mis;
    end
  end

  // -------------------------------------------------------------------------
  // Storage. A store is written at its accepting edge, so a load accepted
  // in the following RESP cycle already sees the new data.
  // -------------------------------------------------------------------------
  // NOTE: the array is built from flops rather than an SRAM macro because
  // reset must clear every byte; an SRAM could not be cleared that way.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (accept && we_i && !req_mis) begin
      for (int k = 0; k < 4; k++) begin
        // Lane addresses wrap byte by byte through the AW-bit adder.
        if (req_be[k]) mem_q[req_addr + AW'(k)] <= wdata_i[8*k +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response formation. With LATENCY=1 the response is captured at the
  // accepting edge, so the fields come straight from the inputs. After a
  // WAIT period they come from the latched copy.
  // -------------------------------------------------------------------------
  logic          cur_we, cur_uns, cur_mis;
  logic [1:0]    cur_size;
  logic [AW-1:0] cur_addr;
  logic [7:0]    rd_b [4];
  logic [31:0]   load_data, resp_data;

  always_comb begin
    if (state_q == ST_WAIT) begin
      cur_we   = we_q;
      cur_size = size_q;
      cur_uns  = uns_q;
      cur_addr = addr_q;
      cur_mis  = mis_q;
    end else begin
      cur_we   = we_i;
      cur_size = size_i;
      cur_uns  = unsigned_i;
      cur_addr = req_addr;
      cur_mis  = req_mis;
    end

    // Reading from the access's own start address gives the same result as
    // selecting a lane of the aligned word.
    for (int k = 0; k < 4; k++) rd_b[k] = mem_q[cur_addr + AW'(k)];

    case (cur_size)
      2'b00:   load_data = {{24{~cur_uns & rd_b[0][7]}}, rd_b[0]};
      2'b01:   load_data = {{16{~cur_uns & rd_b[1][7]}}, rd_b[1], rd_b[0]};
      default: load_data = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
    endcase

    resp_data = (cur_we || cur_mis) ? 32'h0 : load_data;
  end

  // The result registers update only on the edge that enters RESP, so they
  // keep their value until the next response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else if (state_d == ST_RESP) begin
      rdata_q <= resp_data;
      fault_q <= cur_mis;
    end
  end

  assign rdata_o = rdata_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
//
// Directed bench for dmem_ctrl. Two instances share the clock, the reset and
// the access fields. u_dut1 uses LATENCY=1 and covers data-path behaviour.
// u_dut3 uses LATENCY=3 and covers the handshake timing and reset during WAIT.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        uns   = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        req1 = 1'b0;
  logic        ready1, rvalid1, fault1;
  logic [31:0] rdata1;

  logic        req3 = 1'b0;
  logic        ready3, rvalid3, fault3;
  logic [31:0] rdata3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  dmem_ctrl #(.DEPTH_BYTES(1024), .LATENCY(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req1), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready1), .rvalid_o(rvalid1), .rdata_o(rdata1), .fault_o(fault1)
  );

  dmem_ctrl #(.DEPTH_BYTES(1024), .LATENCY(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req3), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready3), .rvalid_o(rvalid3), .rdata_o(rdata3), .fault_o(fault3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    we = wr; size = sz; uns = un; addr = a; wdata = wd;
  endtask

  // One complete access on the LATENCY=1 instance: issue the request, then
  // check the response in the following cycle.
  task automatic access1(input string tag, input logic wr, input logic [1:0] sz,
                         input logic un, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_d,
                         input logic exp_f);
    @(negedge clk_i);
    check({tag, "_idle_rvalid"}, 32'(rvalid1), 32'd0);
    check({tag, "_ready"}, 32'(ready1), 32'd1);
    drive(wr, sz, un, a, wd);
    req1 = 1'b1;
    @(negedge clk_i);
    req1 = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid1), 32'd1);
    check({tag, "_rdata"}, rdata1, exp_d);
    check({tag, "_fault"}, 32'(fault1), 32'(exp_f));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset values ----------------
    @(negedge clk_i);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_fault1", 32'(fault1), 32'd0);
    check("rst_ready3", 32'(ready3), 32'd1);
    check("rst_rvalid3", 32'(rvalid3), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // ---------------- LATENCY=1 data path ----------------
    access1("lw_0x10_clear", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    access1("sb_0x21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFA5, 32'h0, 1'b0);
    access1("lb_0x21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFF_FFA5, 1'b0);
    access1("lbu_0x21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_00A5, 1'b0);
    access1("lw_0x20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0000_A500, 1'b0);

    access1("sw_0x40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 32'h0, 1'b0);
    access1("lhu_0x42", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'h0000_1234, 1'b0);
    access1("lh_0x40", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h0000_5678, 1'b0);
    access1("lw_0x40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1'b0);

    access1("sh_0x50", 1'b1, 2'b01, 1'b0, 32'h50, 32'hAAAA_8001, 32'h0, 1'b0);
    access1("lh_0x50", 1'b0, 2'b01, 1'b0, 32'h50, 32'h0, 32'hFFFF_8001, 1'b0);
    access1("lw_0x50", 1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 32'h0000_8001, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    access1("sw_0x43_mis", 1'b1, 2'b10, 1'b0, 32'h43, 32'hDEAD_BEEF, 32'h0, 1'b1);
    access1("lw_0x40_after_mis", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1'b0);
    access1("sw_0x3fe_mis", 1'b1, 2'b10, 1'b0, 32'h3FE, 32'hCAFE_F00D, 32'h0, 1'b1);
    access1("lw_0x3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0);
    access1("lh_0x51_mis", 1'b0, 2'b01, 1'b0, 32'h51, 32'h0, 32'h0, 1'b1);
`else
    access1("sw_0x43_mis", 1'b1, 2'b10, 1'b0, 32'h43, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access1("lw_0x40_after_mis", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access1("sw_0x3fe", 1'b1, 2'b10, 1'b0, 32'h3FE, 32'hCAFE_F00D, 32'h0, 1'b0);
    access1("lw_0x3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'hCAFE_F00D, 1'b0);
    access1("lbu_0x3ff", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, 32'h0000_00CA, 1'b0);
    access1("lh_0x51_align", 1'b0, 2'b01, 1'b0, 32'h51, 32'h0, 32'hFFFF_8001, 1'b0);
`endif

    // Address 0x400 aliases 0x000.
    access1("sw_0x400", 1'b1, 2'b10, 1'b0, 32'h400, 32'h1122_3344, 32'h0, 1'b0);
    access1("lw_0x000", 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h1122_3344, 1'b0);
    access1("lb_0x403", 1'b0, 2'b00, 1'b0, 32'h403, 32'h0, 32'h0000_0011, 1'b0);

    // Back-to-back: a load accepted in the store's RESP cycle sees the store.
    @(negedge clk_i);
    drive(1'b1, 2'b00, 1'b0, 32'h60, 32'h0000_00F7);
    req1 = 1'b1;
    @(negedge clk_i);
    check("b2b_store_rvalid", 32'(rvalid1), 32'd1);
    check("b2b_store_ready", 32'(ready1), 32'd1);
    check("b2b_store_rdata", rdata1, 32'h0);
    drive(1'b0, 2'b00, 1'b0, 32'h60, 32'h0);
    @(negedge clk_i);
    req1 = 1'b0;
    check("b2b_load_rvalid", 32'(rvalid1), 32'd1);
    check("b2b_load_rdata", rdata1, 32'hFFFF_FFF7);
    @(negedge clk_i);
    check("b2b_done_rvalid", 32'(rvalid1), 32'd0);
    check("b2b_held_rdata", rdata1, 32'hFFFF_FFF7);

    // ---------------- LATENCY=3 handshake ----------------
    // u_dut3 has seen no request so far.
    check("l3_idle_ready", 32'(ready3), 32'd1);
    drive(1'b1, 2'b10, 1'b0, 32'h8, 32'hA1B2_C3D4);
    req3 = 1'b1;
    @(negedge clk_i);            // store accepted at edge T
    check("l3_t1_ready", 32'(ready3), 32'd0);
    check("l3_t1_rvalid", 32'(rvalid3), 32'd0);
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);   // next request held from here
    @(negedge clk_i);
    check("l3_t2_ready", 32'(ready3), 32'd0);
    check("l3_t2_rvalid", 32'(rvalid3), 32'd0);
    @(negedge clk_i);
    check("l3_resp_rvalid", 32'(rvalid3), 32'd1);
    check("l3_resp_ready", 32'(ready3), 32'd1);
    check("l3_resp_rdata", rdata3, 32'h0);
    check("l3_resp_fault", 32'(fault3), 32'd0);
    @(negedge clk_i);            // held load accepted in the RESP cycle
    req3 = 1'b0;
    check("l3_ld_t1_ready", 32'(ready3), 32'd0);
    check("l3_ld_t1_rvalid", 32'(rvalid3), 32'd0);
    @(negedge clk_i);
    check("l3_ld_t2_rvalid", 32'(rvalid3), 32'd0);
    @(negedge clk_i);
    check("l3_ld_rvalid", 32'(rvalid3), 32'd1);
    check("l3_ld_rdata", rdata3, 32'hA1B2_C3D4);
    @(negedge clk_i);
    check("l3_after_rvalid", 32'(rvalid3), 32'd0);
    check("l3_after_ready", 32'(ready3), 32'd1);

    // ---------------- reset during WAIT ----------------
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    req3 = 1'b1;
    @(negedge clk_i);
    req3 = 1'b0;
    check("rw_wait_ready", 32'(ready3), 32'd0);
    rst_i = 1'b1;
    #1;
    check("rw_rst_ready", 32'(ready3), 32'd1);
    check("rw_rst_rvalid", 32'(rvalid3), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check($sformatf("rw_no_pulse_%0d", i), 32'(rvalid3), 32'd0);
    end

    // Reset clears memory in both instances.
    drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    req3 = 1'b1;
    @(negedge clk_i);
    req3 = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rw_clr_rvalid", 32'(rvalid3), 32'd1);
    check("rw_clr_rdata", rdata3, 32'h0);
    access1("post_rst_lw_0x000", 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised byte-addressable data memory for the RISC-V core's load/store path. It serves byte, halfword and word accesses with sign/zero extension for loads and byte-lane writes for stores. Every access uses a request/ready/valid handshake with configurable latency. It sits between the core's LSU and the data bus and replaces the fixed 1 KiB word-only data memory.

## Interface
- DEPTH_BYTES, 1024: memory size in bytes; power of two, ≥ 4.
- LATENCY, 1: cycles from request acceptance to response; legal range 1..7.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  access request; qualified by ready_o.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- unsigned_i  in  1  load only: 1 zero-extends, 0 sign-extends.
- addr_i  in  32  byte address, taken modulo DEPTH_BYTES.
- wdata_i  in  32  store data; the low 8/16/32 bits are used.
- ready_o  out  1  request can be accepted this cycle.
- rvalid_o  out  1  one-cycle completion pulse for both loads and stores.
- rdata_o  out  32  load result; 0 for stores and faults.
- fault_o  out  1  misaligned access; valid only with rvalid_o.

## Operation
- **Byte order:** little-endian. Byte k of a word at address A is held in mem[A+k].
- **Acceptance:** a request is accepted on a rising edge where req_i && ready_o. On acceptance, we_i, size_i, unsigned_i, addr_i and wdata_i are latched.
- **Stores:** memory is written at the accepting edge.
  - Byte writes wdata_i[7:0] to one byte.
  - Halfword writes wdata_i[15:0] to two bytes.
  - Word writes all 32 bits to four bytes.
  - Other bytes are untouched.
- **Loads:** the memory is sampled at the edge that enters RESP. Lane selection and extension:
  - Byte: selected by addr[1:0]; sign bit is bit 7.
  - Halfword: selected by addr[1]; sign bit is bit 15.
  - Word: passed through unchanged.
- **FSM states:**
  - IDLE: ready_o=1.
  - WAIT: ready_o=0; a counter runs down LATENCY-1 cycles.
  - RESP: rvalid_o=1, ready_o=1.
- **FSM transitions:**
  - IDLE → RESP on accept if LATENCY=1, else IDLE → WAIT.
  - WAIT → RESP when the counter reaches 0.
  - RESP → RESP or WAIT on a new accept; otherwise RESP → IDLE.
- **Address wrap-around:** addresses at or above DEPTH_BYTES wrap. Multi-byte accesses near the top wrap byte-by-byte to address 0.
- **Reset:**
  - All bytes are cleared to 0.
  - FSM goes to IDLE and the counter clears.
  - Any in-flight response is dropped; no rvalid_o follows.
- **Back-to-back:** a load accepted in the RESP cycle of a store observes that store's data.

## Timing
- Reset values: ready_o=1, rvalid_o=0, rdata_o=0, fault_o=0.
- For an accept at edge T, rvalid_o is high for exactly the one cycle following edge T+LATENCY-1. The response is therefore visible LATENCY cycles after the request cycle.
- rdata_o and fault_o are registered. They are held until the next response and are meaningful only while rvalid_o=1.
- Throughput is one access per LATENCY cycles. With LATENCY=1, ready_o is constantly 1 and an access completes every cycle.
- req_i while ready_o=0 is ignored. The requester must hold the request until it is accepted.

## Configuration
- **DMEM_MISALIGN_TRAP_EN defined:** misaligned accesses are trapped.
  - Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠00.
  - Such an access is accepted normally and takes the normal latency.
  - A store does not modify memory.
  - The response carries fault_o=1 and rdata_o=0.
- **DMEM_MISALIGN_TRAP_EN undefined:** misalignment is ignored.
  - The address is aligned down: addr[0] is cleared for halfwords, addr[1:0] for words.
  - fault_o is tied to 0.

## Test plan
- **Reset clear:** reset, then word load at 0x10 → rvalid_o one cycle later (LATENCY=1), rdata_o=0x00000000, fault_o=0.
- **Byte store, signed/unsigned load:** byte store 0xA5 to 0x21, then:
  - lb 0x21 → 0xFFFFFFA5.
  - lbu 0x21 → 0x000000A5.
  - Word load 0x20 → 0x0000A500.
- **Halfword and word endianness:** word store 0x12345678 to 0x40, then:
  - lhu 0x42 → 0x00001234.
  - lh 0x40 → 0x00005678.
  - Word load 0x40 → 0x12345678.
- **Latency handshake:** LATENCY=3, load accepted at edge T:
  - ready_o=0 for the two cycles after T.
  - rvalid_o=1 in the third cycle, ready_o=1 in that cycle.
  - A second req_i held high from the cycle after T is accepted in that RESP cycle, not before.
- **Misaligned word store to 0x43:**
  - With the macro: fault_o=1, and word load 0x40 still returns the prior value.
  - Without the macro: the store lands at 0x40.
- **Wrap and reset:**
  - DEPTH_BYTES=1024: a word store to 0x3FE (macro undefined, aligned to 0x3FC) writes bytes 0x3FC..0x3FF.
  - Address 0x400 aliases 0x000.
  - rst_i asserted during WAIT → no rvalid_o pulse afterwards, and ready_o=1 immediately.
